// File: rtl/keypad_scan.sv
// keypad_scan: scans a 5-row x 4-column keypad and debounces whole-frame results.
// Delivers a committed key code plus a level keyReady that only rises for one unambiguous key.
module keypad_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] row_n,
  output logic [3:0] col_n,
  output logic [4:0] key,
  output logic       keyReady
);
  // state | meaning
  // IDLE  | no committed key, keyReady low
  // HELD  | committed key held, keyReady high

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);

  typedef enum logic {IDLE, HELD} state_t;
  state_t state, state_nxt;

  logic [4:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [1:0]       hits, hits_acc;
  logic [4:0]       code, code_acc;
  logic             last_valid;
  logic [4:0]       last_code;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sample, frame_end;
  logic             res_valid, res_same, commit;
  logic [2:0]       col_lows, low_row;
  logic [3:0]       hits_sum;
  logic [4:0]       key_nxt;

  assign sample    = (div == DIV_LAST);
  assign frame_end = sample && (col_idx == 2'd3);
  assign col_n     = ~(4'b0001 << col_idx);
  assign keyReady  = (state == HELD);

  // Count low rows in the driven column and remember the lowest-numbered one.
  always_comb begin
    col_lows = '0;
    low_row  = '0;
    for (int r = 4; r >= 0; r--) begin
      if (!row_s2[r]) begin
        col_lows = col_lows + 3'd1;
        low_row  = 3'(r);
      end
    end
  end

  always_comb begin
    hits_sum  = 4'(hits) + 4'(col_lows);
    hits_acc  = (hits_sum >= 4'd2) ? 2'd2 : hits_sum[1:0];
    code_acc  = (col_lows != 3'd0) ? {low_row, col_idx} : code;
    res_valid = (hits_acc == 2'd1);
    // NONE results compare equal regardless of whatever code was accumulated.
    res_same  = (res_valid == last_valid) && (!res_valid || (code_acc == last_code));
    if (res_same)
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    else
      cnt_nxt = CNT_W'(1);
    commit = frame_end && (cnt_nxt == CNT_MAX);
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key;
    if (commit) begin
      case (state)
        IDLE: if (res_valid) begin
          state_nxt = HELD;
          key_nxt   = code_acc;
        end
        HELD: if (!res_valid) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      key   <= '0;
    end else begin
      state <= state_nxt;
      key   <= key_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_s1     <= '0;
      row_s2     <= '0;
      div        <= '0;
      col_idx    <= '0;
      hits       <= '0;
      code       <= '0;
      last_valid <= 1'b0;
      last_code  <= '0;
      cnt        <= '0;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
      if (sample) begin
        div     <= '0;
        col_idx <= col_idx + 2'd1;
      end else begin
        div <= div + DIV_W'(1);
      end
      if (frame_end) begin
        hits       <= '0;
        code       <= '0;
        last_valid <= res_valid;
        last_code  <= res_valid ? code_acc : 5'd0;
        cnt        <= cnt_nxt;
      end else if (sample) begin
        hits <= hits_acc;
        code <= code_acc;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: directed scenarios then random key patterns, checked every cycle
// against a frame-level model (popcount-based frame result, history-window debounce).
module tb_keypad_scan;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int F        = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  row_n;
  logic [3:0]  col_n;
  logic [4:0]  key;
  logic        keyReady;
  logic [19:0] pressed;

  int vectors     = 0;
  int miscompares = 0;

  int         k;
  int         hist[$];
  logic       m_ready;
  logic [4:0] m_key;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key      (key),
    .keyReady (keyReady)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  function automatic logic [19:0] key_bit(input int i);
    logic [19:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int frame_result(input logic [19:0] p);
    int res;
    res = -1;
    if ($countones(p) == 1)
      for (int i = 0; i < 20; i++) if (p[i]) res = i;
    return res;
  endfunction

  task automatic model_edge();
    int res;
    bit stable;
    if (!rst) begin
      k = 0;
      hist.delete();
      m_ready = 1'b0;
      m_key   = '0;
    end else begin
      k++;
      if (k % F == 0) begin
        res = frame_result(pressed);
        hist.push_back(res);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        stable = (hist.size() == DEBOUNCE);
        foreach (hist[i]) if (hist[i] != res) stable = 1'b0;
        if (stable && !m_ready && res >= 0) begin
          m_ready = 1'b1;
          m_key   = 5'(res);
        end else if (stable && m_ready && res < 0) begin
          m_ready = 1'b0;
        end
      end
    end
  endtask

  task automatic check();
    logic [3:0] exp_col;
    exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
    vectors++;
    assert (col_n === exp_col) else begin
      miscompares++;
      $error("FAIL col_n observed %b expected %b k=%0d", col_n, exp_col, k);
    end
    vectors++;
    assert (keyReady === m_ready) else begin
      miscompares++;
      $error("FAIL keyReady observed %b expected %b k=%0d", keyReady, m_ready, k);
    end
    vectors++;
    assert (key === m_key) else begin
      miscompares++;
      $error("FAIL key observed %b expected %b k=%0d", key, m_key, k);
    end
  endtask

  task automatic check_const(input string tag, input logic rdy_exp, input logic [4:0] key_exp);
    vectors++;
    assert (keyReady === rdy_exp && key === key_exp) else begin
      miscompares++;
      $error("FAIL %s observed ready=%b key=%b expected ready=%b key=%b",
             tag, keyReady, key, rdy_exp, key_exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check();
  endtask

  task automatic run_frames(input int n, input logic [19:0] p);
    pressed = p;
    repeat (n * F) tick();
  endtask

  initial begin
    pressed = '0;
    rst     = 1'b0;
    k       = 0;
    m_ready = 1'b0;
    m_key   = '0;
    repeat (3) tick();
    check_const("reset_values", 1'b0, 5'b00000);
    rst = 1'b1;
    run_frames(2, '0);

    // Up press then release
    run_frames(3, key_bit(10));
    check_const("up_press", 1'b1, 5'b01010);
    run_frames(3, '0);
    check_const("up_release", 1'b0, 5'b01010);

    // Right bouncing on alternate frames
    for (int i = 0; i < 10; i++) run_frames(1, (i % 2 == 0) ? key_bit(15) : 20'd0);
    check_const("bounce", 1'b0, 5'b01010);
    run_frames(2, '0);

    // Prev + Right together, then release Prev
    run_frames(10, key_bit(5) | key_bit(15));
    check_const("multi_key", 1'b0, 5'b01010);
    run_frames(3, key_bit(15));
    check_const("multi_release", 1'b1, 5'b01111);
    run_frames(3, '0);

    // Roll-over Left -> Down with one overlapping frame
    run_frames(3, key_bit(13));
    check_const("left_commit", 1'b1, 5'b01101);
    run_frames(1, key_bit(13) | key_bit(14));
    run_frames(4, key_bit(14));
    check_const("rollover_hold", 1'b1, 5'b01101);
    run_frames(3, '0);
    check_const("rollover_release", 1'b0, 5'b01101);
    run_frames(3, key_bit(14));
    check_const("down_fresh", 1'b1, 5'b01110);
    run_frames(3, '0);

    // Reset pulse mid-frame while Next is committed
    run_frames(3, key_bit(7));
    check_const("next_commit", 1'b1, 5'b00111);
    repeat (7) tick();
    rst = 1'b0;
    tick();
    check_const("reset_mid_hold", 1'b0, 5'b00000);
    rst = 1'b1;
    run_frames(3, key_bit(7));
    check_const("next_recommit", 1'b1, 5'b00111);
    run_frames(3, '0);

    // Random patterns: none, single key, or two keys, held 1..4 frames
    repeat (60) begin
      int kind;
      int a;
      int b;
      logic [19:0] p;
      kind = int'($urandom_range(0, 3));
      a    = int'($urandom_range(0, 19));
      b    = int'($urandom_range(0, 19));
      p    = '0;
      if (kind == 1 || kind == 2) p = key_bit(a);
      else if (kind == 3) p = key_bit(a) | key_bit(b);
      run_frames(int'($urandom_range(1, 4)), p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad front end for the game controller. It scans a 5-row × 4-column keypad and debounces the result. It delivers one stable 5-bit key code plus a level `keyReady` flag to the game logic's `key`/`keyReady` inputs. The game logic acts on the rising edge of `keyReady`; this block guarantees that edge is clean, single, and only occurs for an unambiguous key.

## Interface
- `SCAN_DIV`, 50000: clock cycles each column is driven (dwell). Must be ≥ 4.
- `DEBOUNCE`, 5: consecutive identical full-frame results required to commit a change. Must be ≥ 1.
- `clk`, input, 1: single clock for all logic.
- `rst`, input, 1: reset, synchronous and active-low.
- `row_n`, input, 5: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_n`, output, 4: column drive, active-low. Exactly one bit is low at any time.
- `key`, output, 5: committed key code, `code = row*4 + col`.
- `keyReady`, output, 1: high while a committed key is held.

Codes used by the game logic:
- Prev = 00101 (r1c1), Reset = 00110 (r1c2), Next = 00111 (r1c3).
- Up = 01010 (r2c2), Left = 01101 (r3c1), Down = 01110 (r3c2), Right = 01111 (r3c3).

## Operation
- **Input sync:** `row_n` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- **Scan counters:**
  - `div` counts 0..SCAN_DIV-1, then wraps to 0.
  - `col_idx` (0..3) advances on `div` wrap, wrapping 3 → 0.
  - `col_n = ~(4'b0001 << col_idx)`.
- **Sampling:** when `div == SCAN_DIV-1`, the synchronized rows for `col_idx` are accumulated into the frame:
  - `hits` counts low rows, saturating at 2.
  - `code` records `row*4 + col_idx` for the low row.
- **Frame end:** occurs at the sample with `col_idx == 3`.
  - Frame result = VALID(code) if `hits == 1`, otherwise NONE. Multi-key and ghost patterns therefore count as NONE.
  - The accumulator is cleared for the next frame.
- **Debounce at frame end:**
  - If result equals `last` (same validity and same code): `cnt` increments, saturating at DEBOUNCE.
  - Otherwise: `last <= result`, `cnt <= 1`.
- **Commit:** evaluated at the same frame end, using the updated `cnt == DEBOUNCE`.
  - IDLE (`keyReady = 0`), result VALID: `key <= code`, `keyReady <= 1`, go to HELD.
  - IDLE, result NONE: no change.
  - HELD, result NONE: `keyReady <= 0`, go to IDLE. `key` keeps its last value.
  - HELD, result VALID with a different code: ignored. `keyReady` and `key` stay unchanged until a debounced release. This prevents a lost or double edge.
  - HELD, result VALID with the same code: no change.
- **Widths:** `hits` is 2 bits, `cnt` is `$clog2(DEBOUNCE+1)` bits, `div` is `$clog2(SCAN_DIV)` bits. `code` never exceeds 19.

## Timing
- **Reset** (`rst` low at a `clk` edge) takes effect on that edge:
  - `col_n = 4'b1110`, `key = 0`, `keyReady = 0`.
  - `div`, `col_idx`, `cnt`, `hits` and the synchronizer are all cleared.
  - `last = NONE`, state = IDLE.
  - Reset mid-frame or mid-hold discards all progress. A still-held key re-commits after DEBOUNCE full frames.
- **Frame length:** F = 4·SCAN_DIV cycles. Column 0 is sampled SCAN_DIV-1 cycles after reset release; the first frame ends 4·SCAN_DIV-1 cycles after release.
- **Press latency:** a press stable from cycle t asserts `keyReady` no later than t + 2 + (DEBOUNCE+1)·F cycles, and no earlier than (DEBOUNCE-1)·F after t.
- **Release latency:** release deasserts `keyReady` with the same bounds.
- **Output timing:** `key` and `keyReady` update only on frame-end cycles, registered. `key` is valid in the same cycle `keyReady` rises.
- **Pulse widths:** `keyReady` never pulses shorter than DEBOUNCE·F cycles, high or low.
- **Bounce immunity:** any row glitch shorter than the sampling gap never produces a commit unless it persists for DEBOUNCE frames.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=2, so F = 16.

1. **Reset values:** hold `rst` low for 3 cycles, then release.
   - Required: `col_n = 1110`, `key = 00000`, `keyReady = 0` throughout.
   - Required: `col_n` steps 1110 → 1101 → 1011 → 0111 every 4 cycles, one column low at a time.
2. **Press and release Up** (row 2 low while `col_n[2]` is low).
   - Required: `keyReady` rises with `key = 01010` within 50 cycles and stays high.
   - On release: `keyReady` falls within 50 cycles, and `key` stays 01010.
3. **Bounce rejection:** toggle Right (r3c3) present/absent on alternate frames for 10 frames.
   - Required: `keyReady` stays 0.
4. **Multi-key rejection:** hold Prev (r1c1) and Right (r3c3) together for 10 frames.
   - Required: `keyReady` stays 0. Then release Prev: `keyReady` rises with `key = 01111`.
5. **Roll-over:** commit Left (01101), then press Down and release Left with overlap.
   - Required: `keyReady` stays 1 with `key = 01101` while Down is held.
   - After full release and a fresh Down press: exactly one new rising edge, with `key = 01110`.
6. **Reset mid-hold:** while Next (00111) is committed, pulse `rst` low for 1 cycle.
   - Required: `keyReady = 0` and `key = 0` on the next cycle.
   - With Next still held, `keyReady` reasserts with `key = 00111` within 50 cycles.
